// File: rtl/fp_window_ctrl.sv
// Frame-pointer window controller: sequences CALL/RTN moves for a windowed
// register file, keeps a small stack of saved frame pointers, and reports
// completion and sticky error status to the decode stage.
module fp_window_ctrl #(
    parameter int unsigned FP_W      = 4,
    parameter int unsigned WIN       = 8,
    parameter int unsigned STK_DEPTH = 4
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            Call_Req,
    input  logic            Rtn_Req,
    input  logic [2:0]      Shift_Amt,
    input  logic [15:0]     Link_Data,
    input  logic            Err_Clr,
    output logic            Busy,
    output logic            Done,
    output logic            Err_Overflow,
    output logic            Err_Underflow,
    output logic [FP_W-1:0] FP,
    output logic [2:0]      Depth,
    output logic [FP_W-1:0] New_FP,
    output logic            FP_move,
    output logic            FP_push_up,
    output logic            Rd_Wen,
    output logic [FP_W-1:0] Rd_Addr,
    output logic [15:0]     Rd_Data,
    output logic [2:0]      Actual_Rd,
    output logic [2:0]      Actual_Rs
);

    localparam int unsigned EXT_W    = FP_W + 1;
    localparam int unsigned PTR_W    = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam int unsigned FP_LIMIT = (1 << FP_W) - WIN;
    localparam int unsigned TOP_IDX  = WIN - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FP_W-1:0]   fp_q, fp_d;
    logic [2:0]        depth_q, depth_d;
    logic [FP_W-1:0]   stack_q [STK_DEPTH];
    logic [FP_W-1:0]   stack_d [STK_DEPTH];
    logic              is_call_q, is_call_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [FP_W-1:0]   new_fp_q, new_fp_d;
    logic              fp_move_q, fp_move_d;
    logic              push_up_q, push_up_d;
    logic              rd_wen_q, rd_wen_d;
    logic [FP_W-1:0]   rd_addr_q, rd_addr_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic [2:0]        act_rd_q, act_rd_d;
    logic [2:0]        act_rs_q, act_rs_d;

    logic              call_ok_c;
    logic              rtn_ok_c;

    // Legality of a CALL/RTN against the current window position and stack fill
    always_comb begin
        call_ok_c = (Shift_Amt != 3'd0)
                 && ((EXT_W'(fp_q) + EXT_W'(Shift_Amt)) <= EXT_W'(FP_LIMIT))
                 && (depth_q < 3'(STK_DEPTH));
        rtn_ok_c  = (depth_q != 3'd0);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        fp_d      = fp_q;
        depth_d   = depth_q;
        stack_d   = stack_q;
        is_call_d = is_call_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf_q & ~Err_Clr;
        unf_d     = unf_q & ~Err_Clr;
        new_fp_d  = '0;
        fp_move_d = 1'b0;
        push_up_d = 1'b0;
        rd_wen_d  = 1'b0;
        rd_addr_d = '0;
        rd_data_d = '0;
        act_rd_d  = '0;
        act_rs_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (Call_Req) begin
                    if (call_ok_c) begin
                        state_d   = S_MOVE;
                        busy_d    = 1'b1;
                        is_call_d = 1'b1;
                        fp_move_d = 1'b1;
                        new_fp_d  = fp_q + FP_W'(Shift_Amt);
                        rd_wen_d  = 1'b1;
                        rd_addr_d = fp_q + FP_W'(TOP_IDX);
                        rd_data_d = Link_Data;
                        act_rd_d  = 3'(TOP_IDX);
                        act_rs_d  = Shift_Amt;
                    end else begin
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end else if (Rtn_Req) begin
                    if (rtn_ok_c) begin
                        state_d   = S_MOVE;
                        busy_d    = 1'b1;
                        is_call_d = 1'b0;
                        fp_move_d = 1'b1;
                        push_up_d = 1'b1;
                        new_fp_d  = stack_q[PTR_W'(depth_q - 3'd1)];
                    end else begin
                        unf_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                // Commit the move: frame pointer and stack update together
                state_d = S_SETTLE;
                busy_d  = 1'b1;
                fp_d    = new_fp_q;
                if (is_call_q) begin
                    stack_d[PTR_W'(depth_q)] = fp_q;
                    depth_d = depth_q + 3'd1;
                end else begin
                    depth_d = depth_q - 3'd1;
                end
            end
            S_SETTLE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            fp_q      <= '0;
            depth_q   <= '0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            is_call_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            new_fp_q  <= '0;
            fp_move_q <= 1'b0;
            push_up_q <= 1'b0;
            rd_wen_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            act_rd_q  <= '0;
            act_rs_q  <= '0;
        end else begin
            state_q   <= state_d;
            fp_q      <= fp_d;
            depth_q   <= depth_d;
            stack_q   <= stack_d;
            is_call_q <= is_call_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            new_fp_q  <= new_fp_d;
            fp_move_q <= fp_move_d;
            push_up_q <= push_up_d;
            rd_wen_q  <= rd_wen_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            act_rd_q  <= act_rd_d;
            act_rs_q  <= act_rs_d;
        end
    end

    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Err_Overflow  = ovf_q;
    assign Err_Underflow = unf_q;
    assign FP            = fp_q;
    assign Depth         = depth_q;
    assign New_FP        = new_fp_q;
    assign FP_move       = fp_move_q;
    assign FP_push_up    = push_up_q;
    assign Rd_Wen        = rd_wen_q;
    assign Rd_Addr       = rd_addr_q;
    assign Rd_Data       = rd_data_q;
    assign Actual_Rd     = act_rd_q;
    assign Actual_Rs     = act_rs_q;

endmodule

// File: tb/tb_fp_window_ctrl.sv
// Scoreboard bench for fp_window_ctrl: stimulus pushes expected move and
// completion records; a monitor pops and compares them as the DUT shows them.
module tb_fp_window_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic        Call_Req;
    logic        Rtn_Req;
    logic [2:0]  Shift_Amt;
    logic [15:0] Link_Data;
    logic        Err_Clr;
    logic        Busy;
    logic        Done;
    logic        Err_Overflow;
    logic        Err_Underflow;
    logic [3:0]  FP;
    logic [2:0]  Depth;
    logic [3:0]  New_FP;
    logic        FP_move;
    logic        FP_push_up;
    logic        Rd_Wen;
    logic [3:0]  Rd_Addr;
    logic [15:0] Rd_Data;
    logic [2:0]  Actual_Rd;
    logic [2:0]  Actual_Rs;

    fp_window_ctrl dut (
        .Clock(Clock), .Reset_n(Reset_n), .Call_Req(Call_Req), .Rtn_Req(Rtn_Req),
        .Shift_Amt(Shift_Amt), .Link_Data(Link_Data), .Err_Clr(Err_Clr),
        .Busy(Busy), .Done(Done), .Err_Overflow(Err_Overflow),
        .Err_Underflow(Err_Underflow), .FP(FP), .Depth(Depth), .New_FP(New_FP),
        .FP_move(FP_move), .FP_push_up(FP_push_up), .Rd_Wen(Rd_Wen),
        .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Actual_Rd(Actual_Rd),
        .Actual_Rs(Actual_Rs)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  old_fp;
        logic [3:0]  new_fp;
        logic        push_up;
        logic        wen;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [2:0]  rd;
        logic [2:0]  rs;
    } mv_t;

    typedef struct {
        int         cyc;
        logic [3:0] fp;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
    } dn_t;

    mv_t         mq[$];
    dn_t         dq[$];
    int          n_pass;
    int          n_total;
    int          cyc;
    logic [3:0]  cur_fp;
    logic [15:0] rf_m [16];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Register-file model fed by the write port
    always @(posedge Clock) begin
        if (Rd_Wen) rf_m[Rd_Addr] <= Rd_Data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare each move cycle and each completion against the queues
    initial begin
        mv_t m;
        dn_t d;
        forever begin
            @(negedge Clock);
            if (FP_move) begin
                if (mq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_move: FP_move=1 with nothing expected (t=%0t)", $time);
                end else begin
                    m = mq.pop_front();
                    chk("move_cycle",  cyc,        m.cyc);
                    chk("move_new_fp", New_FP,     m.new_fp);
                    chk("move_push",   FP_push_up, m.push_up);
                    chk("move_wen",    Rd_Wen,     m.wen);
                    chk("move_addr",   Rd_Addr,    m.addr);
                    chk("move_data",   Rd_Data,    m.data);
                    chk("move_rd",     Actual_Rd,  m.rd);
                    chk("move_rs",     Actual_Rs,  m.rs);
                    chk("move_old_fp", FP,         m.old_fp);
                    chk("move_busy",   Busy,       1);
                end
            end
            if (Done) begin
                if (dq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: Done=1 with nothing expected (t=%0t)", $time);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", cyc,           d.cyc);
                    chk("done_fp",    FP,            d.fp);
                    chk("done_depth", Depth,         d.depth);
                    chk("done_ovf",   Err_Overflow,  d.ovf);
                    chk("done_unf",   Err_Underflow, d.unf);
                    chk("done_busy",  Busy,          0);
                end
            end
        end
    end

    // Issue one request held for 'hold' edges, push expectations, wait for Done
    task automatic req(input logic c, input logic r, input logic clr,
                       input logic [2:0] i, input logic [15:0] link, input int hold,
                       input logic legal, input logic [3:0] fp_after,
                       input logic [2:0] depth_after, input logic ovf, input logic unf);
        mv_t m;
        dn_t d;
        @(negedge Clock);
        if (legal) begin
            m.cyc     = cyc + 1;
            m.old_fp  = cur_fp;
            m.new_fp  = fp_after;
            m.push_up = ~c;
            m.wen     = c;
            m.addr    = c ? cur_fp + 4'd7 : 4'd0;
            m.data    = c ? link : 16'h0;
            m.rd      = c ? 3'd7 : 3'd0;
            m.rs      = c ? i : 3'd0;
            mq.push_back(m);
            d.cyc = cyc + 3;
        end else begin
            d.cyc = cyc + 1;
        end
        d.fp    = fp_after;
        d.depth = depth_after;
        d.ovf   = ovf;
        d.unf   = unf;
        dq.push_back(d);
        Call_Req  = c;
        Rtn_Req   = r;
        Err_Clr   = clr;
        Shift_Amt = i;
        Link_Data = link;
        repeat (hold) @(negedge Clock);
        Call_Req = 1'b0;
        Rtn_Req  = 1'b0;
        Err_Clr  = 1'b0;
        cur_fp   = fp_after;
        for (int n = 0; n < 20 && dq.size() != 0; n++) @(negedge Clock);
        if (dq.size() != 0) begin
            n_total++;
            $display("FAIL done_timeout: %0d completions still pending", dq.size());
            dq.delete();
            mq.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        cur_fp  = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] idx;
        n_pass = 0; n_total = 0; cur_fp = 4'd0;
        for (int k = 0; k < 16; k++) rf_m[k] = 16'h0;
        Reset_n = 1'b0; Call_Req = 1'b0; Rtn_Req = 1'b0; Err_Clr = 1'b0;
        Shift_Amt = 3'd0; Link_Data = 16'h0;
        repeat (3) @(negedge Clock);
        chk("rst_fp",      FP,            0);
        chk("rst_depth",   Depth,         0);
        chk("rst_busy",    Busy,          0);
        chk("rst_done",    Done,          0);
        chk("rst_move",    FP_move,       0);
        chk("rst_wen",     Rd_Wen,        0);
        chk("rst_ovf",     Err_Overflow,  0);
        chk("rst_unf",     Err_Underflow, 0);
        chk("rst_new_fp",  New_FP,        0);
        Reset_n = 1'b1;

        // c  r  clr i     link      hold legal fp  depth ovf unf
        req(1, 0, 0, 3'd3, 16'hBEEF, 1, 1, 4'd3, 3'd1, 0, 0);
        idx = FP + 4'd4;
        chk("rf_win4_link", rf_m[idx], 16'hBEEF);
        req(1, 0, 0, 3'd2, 16'h1234, 1, 1, 4'd5, 3'd2, 0, 0);
        req(0, 1, 0, 3'd0, 16'h0,    1, 1, 4'd3, 3'd1, 0, 0);
        req(0, 1, 0, 3'd0, 16'h0,    1, 1, 4'd0, 3'd0, 0, 0);
        req(1, 0, 0, 3'd5, 16'h5555, 1, 1, 4'd5, 3'd1, 0, 0);
        req(1, 0, 0, 3'd4, 16'h9999, 1, 0, 4'd5, 3'd1, 1, 0);
        req(1, 0, 0, 3'd3, 16'h6666, 1, 1, 4'd8, 3'd2, 1, 0);
        req(0, 1, 0, 3'd0, 16'h0,    1, 1, 4'd5, 3'd1, 1, 0);
        @(negedge Clock); Err_Clr = 1'b1;
        @(negedge Clock); Err_Clr = 1'b0;
        chk("err_clr_ovf", Err_Overflow, 0);

        do_reset();
        req(0, 1, 0, 3'd0, 16'h0,    1, 0, 4'd0, 3'd0, 0, 1);
        req(1, 0, 0, 3'd0, 16'h4321, 1, 0, 4'd0, 3'd0, 1, 1);
        req(0, 1, 1, 3'd0, 16'h0,    1, 0, 4'd0, 3'd0, 0, 1);
        req(1, 0, 0, 3'd2, 16'hAAAA, 1, 1, 4'd2, 3'd1, 0, 1);
        req(1, 1, 0, 3'd1, 16'hBBBB, 3, 1, 4'd3, 3'd2, 0, 1);

        do_reset();
        req(1, 0, 0, 3'd1, 16'h1000, 1, 1, 4'd1, 3'd1, 0, 0);
        req(1, 0, 0, 3'd1, 16'h1001, 1, 1, 4'd2, 3'd2, 0, 0);
        req(1, 0, 0, 3'd1, 16'h1002, 1, 1, 4'd3, 3'd3, 0, 0);
        req(1, 0, 0, 3'd1, 16'h1003, 1, 1, 4'd4, 3'd4, 0, 0);
        req(1, 0, 0, 3'd1, 16'h1004, 1, 0, 4'd4, 3'd4, 1, 0);

        // Asynchronous reset asserted in the middle of a MOVE cycle
        @(negedge Clock);
        Rtn_Req = 1'b1;
        @(posedge Clock);
        #1;
        Rtn_Req = 1'b0;
        chk("mid_move_active", FP_move, 1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_move",  FP_move, 0);
        chk("async_rst_fp",    FP,      0);
        chk("async_rst_depth", Depth,   0);
        chk("async_rst_busy",  Busy,    0);
        @(negedge Clock);
        Reset_n = 1'b1;
        cur_fp  = 4'd0;

        req(1, 0, 0, 3'd2, 16'h7777, 1, 1, 4'd2, 3'd1, 0, 0);
        req(0, 1, 0, 3'd0, 16'h0,    1, 1, 4'd0, 3'd0, 0, 0);
        req(0, 1, 0, 3'd0, 16'h0,    1, 0, 4'd0, 3'd0, 0, 1);

        repeat (4) @(negedge Clock);
        chk("moves_drained", mq.size(), 0);
        chk("dones_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
